// File: rtl/mapa_arbitro.sv
// Map write-port arbiter: grants cobra/fruta/obstaculo writes one per cycle and runs a full-map clear sweep.
// Define MAPA_ARB_RR_EN for round-robin arbitration; otherwise fixed priority cobra > fruta > obstaculo.
module mapa_arbitro #(
    parameter int MAPA_WIDTH  = 80,
    parameter int MAPA_HEIGHT = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cobra_req,
    input  logic       fruta_req,
    input  logic       obstaculo_req,
    input  logic [9:0] cobra_x,
    input  logic [9:0] fruta_x,
    input  logic [9:0] obstaculo_x,
    input  logic [9:0] cobra_y,
    input  logic [9:0] fruta_y,
    input  logic [9:0] obstaculo_y,
    input  logic       cobra_dado,
    input  logic       fruta_dado,
    input  logic       obstaculo_dado,
    output logic       cobra_ack,
    output logic       fruta_ack,
    output logic       obstaculo_ack,
    input  logic       clear_start,
    output logic       map_write,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    output logic [3:0] map_dado,
    output logic       clear_busy,
    output logic       clear_done
);

    localparam logic [9:0] LAST_X = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0] LAST_Y = 10'(MAPA_HEIGHT - 1);

    localparam logic [3:0] DADO_NADA      = 4'd0;
    localparam logic [3:0] DADO_COBRA     = 4'd1;
    localparam logic [3:0] DADO_FRUTA     = 4'd2;
    localparam logic [3:0] DADO_OBSTACULO = 4'd3;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t     r_state, w_state_next;
    logic       r_map_write, w_map_write_next;
    logic [2:0] r_ack, w_ack_next;
    logic [9:0] r_map_x, w_map_x_next;
    logic [9:0] r_map_y, w_map_y_next;
    logic [3:0] r_map_dado, w_map_dado_next;
    logic       r_clear_busy, w_clear_busy_next;
    logic       r_clear_done, w_clear_done_next;
    logic [9:0] r_sx, w_sx_next;
    logic [9:0] r_sy, w_sy_next;

    logic [2:0] w_req;
    logic [2:0] w_gnt;

    // A requester whose ack is high this cycle is still holding its old request.
    assign w_req = {obstaculo_req, fruta_req, cobra_req} & ~r_ack;

`ifdef MAPA_ARB_RR_EN
    logic [1:0] r_ptr, w_ptr_next;
    logic [1:0] w_order [3];
    logic       w_take;

    for (genvar gi = 0; gi < 3; gi++) begin : g_order
        assign w_order[gi] = 2'((int'(r_ptr) + gi) % 3);
    end

    always_comb begin
        w_gnt      = 3'b000;
        w_ptr_next = r_ptr;
        for (int k = 0; k < 3; k++) begin
            if (w_gnt == 3'b000 && w_req[w_order[k]]) begin
                w_gnt[w_order[k]] = 1'b1;
                w_ptr_next        = (w_order[k] == 2'd2) ? 2'd0 : w_order[k] + 2'd1;
            end
        end
    end

    assign w_take = (r_state == ST_ARB) && !clear_start && (w_gnt != 3'b000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_take) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    always_comb begin
        w_gnt = 3'b000;
        if (w_req[0]) begin
            w_gnt = 3'b001;
        end else if (w_req[1]) begin
            w_gnt = 3'b010;
        end else if (w_req[2]) begin
            w_gnt = 3'b100;
        end
    end
`endif

    always_comb begin
        w_state_next      = r_state;
        w_map_write_next  = 1'b0;
        w_ack_next        = 3'b000;
        w_map_x_next      = r_map_x;
        w_map_y_next      = r_map_y;
        w_map_dado_next   = r_map_dado;
        w_clear_busy_next = 1'b0;
        w_clear_done_next = 1'b0;
        w_sx_next         = r_sx;
        w_sy_next         = r_sy;

        case (r_state)
            ST_ARB: begin
                if (clear_start) begin
                    // The first sweep cell is written on the entry edge itself.
                    w_state_next      = ST_CLEAR;
                    w_map_write_next  = 1'b1;
                    w_map_x_next      = 10'd0;
                    w_map_y_next      = 10'd0;
                    w_map_dado_next   = DADO_NADA;
                    w_clear_busy_next = 1'b1;
                    w_sx_next         = 10'd0;
                    w_sy_next         = 10'd0;
                end else if (w_gnt != 3'b000) begin
                    w_map_write_next = 1'b1;
                    w_ack_next       = w_gnt;
                    if (w_gnt[0]) begin
                        w_map_x_next    = cobra_x;
                        w_map_y_next    = cobra_y;
                        w_map_dado_next = cobra_dado ? DADO_COBRA : DADO_NADA;
                    end else if (w_gnt[1]) begin
                        w_map_x_next    = fruta_x;
                        w_map_y_next    = fruta_y;
                        w_map_dado_next = fruta_dado ? DADO_FRUTA : DADO_NADA;
                    end else begin
                        w_map_x_next    = obstaculo_x;
                        w_map_y_next    = obstaculo_y;
                        w_map_dado_next = obstaculo_dado ? DADO_OBSTACULO : DADO_NADA;
                    end
                end
            end
            ST_CLEAR: begin
                if (r_sx == LAST_X && r_sy == LAST_Y) begin
                    w_state_next      = ST_ARB;
                    w_clear_done_next = 1'b1;
                end else begin
                    if (r_sx == LAST_X) begin
                        w_sx_next = 10'd0;
                        w_sy_next = r_sy + 10'd1;
                    end else begin
                        w_sx_next = r_sx + 10'd1;
                    end
                    w_map_write_next  = 1'b1;
                    w_map_x_next      = w_sx_next;
                    w_map_y_next      = w_sy_next;
                    w_map_dado_next   = DADO_NADA;
                    w_clear_busy_next = 1'b1;
                end
            end
            default: w_state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ARB;
            r_map_write  <= 1'b0;
            r_ack        <= 3'b000;
            r_map_x      <= 10'd0;
            r_map_y      <= 10'd0;
            r_map_dado   <= 4'd0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_sx         <= 10'd0;
            r_sy         <= 10'd0;
        end else begin
            r_state      <= w_state_next;
            r_map_write  <= w_map_write_next;
            r_ack        <= w_ack_next;
            r_map_x      <= w_map_x_next;
            r_map_y      <= w_map_y_next;
            r_map_dado   <= w_map_dado_next;
            r_clear_busy <= w_clear_busy_next;
            r_clear_done <= w_clear_done_next;
            r_sx         <= w_sx_next;
            r_sy         <= w_sy_next;
        end
    end

    assign cobra_ack     = r_ack[0];
    assign fruta_ack     = r_ack[1];
    assign obstaculo_ack = r_ack[2];
    assign map_write     = r_map_write;
    assign map_x         = r_map_x;
    assign map_y         = r_map_y;
    assign map_dado      = r_map_dado;
    assign clear_busy    = r_clear_busy;
    assign clear_done    = r_clear_done;

endmodule

// File: tb/tb_mapa_arbitro.sv
// Bench for mapa_arbitro: vector table plus grant-order, clear-sweep and async-reset sequences.
module tb_mapa_arbitro;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cobra_req = 0, fruta_req = 0, obstaculo_req = 0;
    logic [9:0] cobra_x = 0, fruta_x = 0, obstaculo_x = 0;
    logic [9:0] cobra_y = 0, fruta_y = 0, obstaculo_y = 0;
    logic       cobra_dado = 0, fruta_dado = 0, obstaculo_dado = 0;
    logic       cobra_ack, fruta_ack, obstaculo_ack;
    logic       clear_start = 0;
    logic       map_write;
    logic [9:0] map_x, map_y;
    logic [3:0] map_dado;
    logic       clear_busy, clear_done;

    always #5 clk = ~clk;

    mapa_arbitro #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .cobra_req(cobra_req), .fruta_req(fruta_req), .obstaculo_req(obstaculo_req),
        .cobra_x(cobra_x), .fruta_x(fruta_x), .obstaculo_x(obstaculo_x),
        .cobra_y(cobra_y), .fruta_y(fruta_y), .obstaculo_y(obstaculo_y),
        .cobra_dado(cobra_dado), .fruta_dado(fruta_dado), .obstaculo_dado(obstaculo_dado),
        .cobra_ack(cobra_ack), .fruta_ack(fruta_ack), .obstaculo_ack(obstaculo_ack),
        .clear_start(clear_start),
        .map_write(map_write), .map_x(map_x), .map_y(map_y), .map_dado(map_dado),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    typedef struct {
        logic [2:0] req;   // {obstaculo, fruta, cobra}
        logic [2:0] dado;
        logic [9:0] cx, cy, fx, fy, ox, oy;
        logic       clr;
    } in_t;

    typedef struct {
        logic       w;
        logic [2:0] ack;
        logic [9:0] x, y;
        logic [3:0] d;
        logic       busy, done;
        logic       cxy;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    function automatic in_t mi(logic [2:0] req, logic [2:0] dd, int cx, int cy, int fx, int fy,
                               int ox, int oy, logic clr);
        in_t v;
        v.req = req; v.dado = dd;
        v.cx = 10'(cx); v.cy = 10'(cy); v.fx = 10'(fx); v.fy = 10'(fy);
        v.ox = 10'(ox); v.oy = 10'(oy); v.clr = clr;
        return v;
    endfunction

    function automatic exp_t ex(logic w, logic [2:0] a, int x, int y, int d, logic b, logic dn);
        exp_t e;
        e.w = w; e.ack = a; e.x = 10'(x); e.y = 10'(y); e.d = 4'(d);
        e.busy = b; e.done = dn; e.cxy = w;
        return e;
    endfunction

    task automatic check(input exp_t e, input string nm);
        logic bad;
        n_vec++;
        bad = (map_write !== e.w) || ({obstaculo_ack, fruta_ack, cobra_ack} !== e.ack) ||
              (clear_busy !== e.busy) || (clear_done !== e.done);
        if (e.cxy) bad = bad || (map_x !== e.x) || (map_y !== e.y) || (map_dado !== e.d);
        if (bad) begin
            n_err++;
            $display("FAIL %s: got w=%0b ack=%b x=%0d y=%0d d=%0d busy=%0b done=%0b, want w=%0b ack=%b x=%0d y=%0d d=%0d busy=%0b done=%0b",
                     nm, map_write, {obstaculo_ack, fruta_ack, cobra_ack}, map_x, map_y, map_dado,
                     clear_busy, clear_done, e.w, e.ack, e.x, e.y, e.d, e.busy, e.done);
        end else begin
            $display("ok   %s: w=%0b ack=%b x=%0d y=%0d d=%0d busy=%0b done=%0b",
                     nm, map_write, {obstaculo_ack, fruta_ack, cobra_ack}, map_x, map_y, map_dado,
                     clear_busy, clear_done);
        end
    endtask

    // Drive inputs on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic step(input in_t v, input exp_t e, input string nm);
        exp_t got;
        @(negedge clk);
        {obstaculo_req, fruta_req, cobra_req}    = v.req;
        {obstaculo_dado, fruta_dado, cobra_dado} = v.dado;
        cobra_x = v.cx; cobra_y = v.cy;
        fruta_x = v.fx; fruta_y = v.fy;
        obstaculo_x = v.ox; obstaculo_y = v.oy;
        clear_start = v.clr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got nothing, want one entry", nm);
        end else begin
            got = sb_q.pop_front();
            check(got, nm);
        end
    endtask

    vec_t tbl[12];
    int   order[6];
    exp_t e0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0),        ex(0, 3'b000, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mi(3'b001, 3'b001, 5, 7, 0, 0, 0, 0, 0),        ex(1, 3'b001, 5, 7, 1, 0, 0)};
        tbl[2]  = '{mi(3'b001, 3'b001, 5, 7, 0, 0, 0, 0, 0),        ex(0, 3'b000, 0, 0, 0, 0, 0)};
        tbl[3]  = '{mi(3'b010, 3'b000, 0, 0, 9, 2, 0, 0, 0),        ex(1, 3'b010, 9, 2, 0, 0, 0)};
        tbl[4]  = '{mi(3'b100, 3'b100, 0, 0, 0, 0, 100, 200, 0),    ex(1, 3'b100, 100, 200, 3, 0, 0)};
        tbl[5]  = '{mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0),        ex(0, 3'b000, 0, 0, 0, 0, 0)};
        tbl[6]  = '{mi(3'b010, 3'b010, 0, 0, 1023, 1023, 0, 0, 0),  ex(1, 3'b010, 1023, 1023, 2, 0, 0)};
        tbl[7]  = '{mi(3'b011, 3'b011, 3, 3, 4, 4, 0, 0, 0),        ex(1, 3'b001, 3, 3, 1, 0, 0)};
        tbl[8]  = '{mi(3'b010, 3'b010, 0, 0, 4, 4, 0, 0, 0),        ex(1, 3'b010, 4, 4, 2, 0, 0)};
        tbl[9]  = '{mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0),        ex(0, 3'b000, 0, 0, 0, 0, 0)};
        tbl[10] = '{mi(3'b100, 3'b000, 0, 0, 0, 0, 2, 1, 0),        ex(1, 3'b100, 2, 1, 0, 0, 0)};
        tbl[11] = '{mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0),        ex(0, 3'b000, 0, 0, 0, 0, 0)};

        // Reset state while rst_n is held low.
        #13;
        e0 = ex(0, 3'b000, 0, 0, 0, 0, 0);
        e0.cxy = 1'b1;
        check(e0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].i, tbl[i].e, $sformatf("vec%0d", i));
        end

        // All three requesters held: grant order depends on arbitration mode.
`ifdef MAPA_ARB_RR_EN
        order = '{0, 1, 2, 0, 1, 2};
`else
        order = '{0, 1, 0, 1, 0, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            step(mi(3'b111, 3'b111, 10, 11, 20, 21, 30, 31, 0),
                 ex(1, 3'(1 << order[i]), 10 * (order[i] + 1), 10 * (order[i] + 1) + 1, order[i] + 1, 0, 0),
                 $sformatf("all3_%0d", i));
        end
        step(mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0), ex(0, 3'b000, 0, 0, 0, 0, 0), "all3_idle");

        // Clear sweep with a competing fruta request held throughout.
        for (int k = 0; k < W * H; k++) begin
            step(mi(3'b010, 3'b010, 0, 0, 2, 2, 0, 0, (k < 3) ? 1'b1 : 1'b0),
                 ex(1, 3'b000, k % W, k / W, 0, 1, 0), $sformatf("sweep_%0d", k));
        end
        step(mi(3'b010, 3'b010, 0, 0, 2, 2, 0, 0, 0), ex(0, 3'b000, 0, 0, 0, 0, 1), "sweep_done");
        step(mi(3'b010, 3'b010, 0, 0, 2, 2, 0, 0, 0), ex(1, 3'b010, 2, 2, 2, 0, 0), "sweep_fruta_ack");
        step(mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0), ex(0, 3'b000, 0, 0, 0, 0, 0), "sweep_idle");

        // Asynchronous reset at the 5th sweep write.
        for (int k = 0; k < 5; k++) begin
            step(mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, (k == 0) ? 1'b1 : 1'b0),
                 ex(1, 3'b000, k % W, k / W, 0, 1, 0), $sformatf("rst_sweep_%0d", k));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check(e0, "async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0), ex(0, 3'b000, 0, 0, 0, 0, 0),
                 $sformatf("post_rst_idle_%0d", k));
        end
        step(mi(3'b001, 3'b001, 6, 1, 0, 0, 0, 0, 0), ex(1, 3'b001, 6, 1, 1, 0, 0), "post_rst_grant");
        step(mi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0), ex(0, 3'b000, 0, 0, 0, 0, 0), "post_rst_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mapa_arbitro.md
MAPA_ARBITRO -- requirements
Module: mapa_arbitro

Interface
REQ-001 SHALL have parameter MAPA_WIDTH, default 80: map columns; x range 0..MAPA_WIDTH-1.
REQ-002 SHALL have parameter MAPA_HEIGHT, default 60: map rows; y range 0..MAPA_HEIGHT-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cobra_req / fruta_req / obstaculo_req  input  1 each  write request, held until acked.
REQ-006 SHALL have ports cobra_x / fruta_x / obstaculo_x and cobra_y / fruta_y / obstaculo_y  input  10 each  target cell.
REQ-007 SHALL have ports cobra_dado / fruta_dado / obstaculo_dado  input  1 each  1 = place, 0 = erase.
REQ-008 SHALL have ports cobra_ack / fruta_ack / obstaculo_ack  output  1 each  one-cycle grant pulse.
REQ-009 SHALL have port clear_start  input  1  request full-map erase sweep.
REQ-010 SHALL have ports map_write  output  1, map_x  output  10, map_y  output  10, map_dado  output  4  single map write port.
REQ-011 SHALL have ports clear_busy  output  1 and clear_done  output  1  sweep status.

Function
REQ-012 SHALL implement two states: ARB and CLEAR.
REQ-013 SHALL register all outputs; a request sampled at edge N is written at edge N+1: map_write=1 and the matching ack=1 in the same cycle.
REQ-014 SHALL issue at most one map write per cycle.
REQ-015 SHALL mask a requester's req while its ack is high, so a held req never double-grants.
REQ-016 SHALL encode map_dado as 0 (NADA) when the granted dado=0; otherwise cobra 1, fruta 2, obstaculo 3.
REQ-017 SHALL drive map_x/map_y from the granted requester's inputs, captured on the grant edge.
REQ-018 SHALL hold map_write=0 and all acks 0 in ARB when no unmasked req is present; map_x, map_y and map_dado hold their last values.
REQ-019 SHALL enter CLEAR from ARB on clear_start=1; clear_start outranks simultaneous reqs, which stay pending and unacked.
REQ-020 SHALL ignore clear_start while in CLEAR.
REQ-021 SHALL, in CLEAR, write map_dado=0 to one cell per cycle, y outer and x inner, from (0,0) to (MAPA_WIDTH-1, MAPA_HEIGHT-1): exactly MAPA_WIDTH*MAPA_HEIGHT writes.
REQ-022 SHALL wrap x to 0 and increment y after x = MAPA_WIDTH-1.
REQ-023 SHALL hold clear_busy=1 from the first to the last sweep write inclusive.
REQ-024 SHALL pulse clear_done for one cycle in the cycle after the last sweep write and return to ARB then; grants resume the following cycle.
REQ-025 SHALL assert no acks during CLEAR.
REQ-026 SHALL pass requests with out-of-range coordinates unchanged; range checking is not performed.

Reset
REQ-027 SHALL, on rst_n=0, immediately force: state ARB; map_write, all acks, clear_busy and clear_done 0; map_x, map_y, map_dado and sweep counters 0; round-robin pointer to cobra.
REQ-028 SHALL abandon a sweep in progress on reset, with no resume.
REQ-029 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL select round-robin arbitration when MAPA_ARB_RR_EN is defined: priority order starts after the last granted requester, cycling cobra -> fruta -> obstaculo -> cobra.
REQ-031 SHALL use fixed priority cobra > fruta > obstaculo when MAPA_ARB_RR_EN is undefined; the pointer logic is absent.

Verification
REQ-032 SHALL cover: cobra_req=1, (5,7), dado=1 at edge N -> at edge N+1 map_write=1, map_x=5, map_y=7, map_dado=1, cobra_ack=1; req held 1 more cycle -> no second write.
REQ-033 SHALL cover: all three reqs held 1 for 6 cycles, macro undefined -> acks cobra, fruta, cobra, fruta, ...; obstaculo starved.
REQ-034 SHALL cover: all three reqs held, MAPA_ARB_RR_EN defined -> acks cobra, fruta, obstaculo, cobra, fruta, obstaculo.
REQ-035 SHALL cover: MAPA_WIDTH=4, MAPA_HEIGHT=3, clear_start with fruta_req=1 -> 12 consecutive writes (0,0)..(3,2), dado 0, clear_busy=1 throughout; clear_done next cycle; fruta_ack the cycle after.
REQ-036 SHALL cover: rst_n=0 asynchronously at the 5th sweep write -> outputs 0 with no clock edge; after release, ARB with no clear_done pulse.
